// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor
//   Per-cycle pipeline event counter. Counts RUN cycles, hazard stalls (not
//   blamed on a same-cycle jump/branch), IF/ID flushes and WB retires while
//   the FSM is in RUN. It raises halt_o once the RUN-cycle budget is used up,
//   and exposes a req/valid/ack snapshot port that freezes the four counters.
//
// Parameters
//   CNT_W       width of every counter and snapshot register
//   MAX_CYCLES  RUN cycles before halt; 0 disables the budget
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   start_i                 high = run, low = pause
//   hd_stall_i, jump_i,
//   branch_i, flush_i,
//   retire_i                per-cycle pipeline event strobes
//   clr_i                   synchronous clear of counters and halt
//   snap_req_i, snap_ack_i  snapshot request pulse / consumer accept
//   *_cnt_o                 live counters
//   snap_*_o, snap_valid_o  frozen snapshot and its hold flag
//   halt_o, state_o         budget exhausted / FSM state (00 IDLE, 01 RUN, 10 HALT)
module pipeline_perf_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             hd_stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             clr_i,
    input  logic             snap_req_i,
    input  logic             snap_ack_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] snap_cyc_o,
    output logic [CNT_W-1:0] snap_stl_o,
    output logic [CNT_W-1:0] snap_fls_o,
    output logic [CNT_W-1:0] snap_ret_o,
    output logic             snap_valid_o,
    output logic             halt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    // Budget comparison is done at least 32 bits wide so a narrow counter
    // that saturates below MAX_CYCLES never matches a truncated budget.
    localparam int unsigned MW = (CNT_W > 32) ? CNT_W : 32;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cyc, stl, fls, ret;
    logic [CNT_W-1:0] cyc_nxt, stl_nxt, fls_nxt, ret_nxt;
    logic [CNT_W-1:0] snap_cyc, snap_stl, snap_fls, snap_ret;
    logic             snap_valid;
    logic             budget_hit;
    logic             capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        cyc_nxt   = cyc;
        stl_nxt   = stl;
        fls_nxt   = fls;
        ret_nxt   = ret;
        state_nxt = state;

        if (state == RUN) begin
            cyc_nxt = sat_inc(cyc);
            if (hd_stall_i && !jump_i && !branch_i) stl_nxt = sat_inc(stl);
            if (flush_i)  fls_nxt = sat_inc(fls);
            if (retire_i) ret_nxt = sat_inc(ret);
        end

        budget_hit = (MAX_CYCLES != 0) && (MW'(cyc_nxt) == MW'(MAX_CYCLES));

        unique case (state)
            IDLE:    state_nxt = start_i ? RUN : IDLE;
            RUN:     state_nxt = budget_hit ? HALT : (start_i ? RUN : IDLE);
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase

        // Clear overrides both the increments and the RUN->HALT transition.
        if (clr_i) begin
            cyc_nxt   = '0;
            stl_nxt   = '0;
            fls_nxt   = '0;
            ret_nxt   = '0;
            state_nxt = start_i ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cyc   <= '0;
            stl   <= '0;
            fls   <= '0;
            ret   <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            stl   <= stl_nxt;
            fls   <= fls_nxt;
            ret   <= ret_nxt;
        end
    end

    // A request is taken when no snapshot is held, or when the held one is
    // acknowledged in the same cycle (back-to-back re-capture, valid stays 1).
    // Captured values are the registered counts, i.e. pre-clear on a clr cycle.
    assign capture = snap_req_i && (!snap_valid || snap_ack_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_cyc   <= '0;
            snap_stl   <= '0;
            snap_fls   <= '0;
            snap_ret   <= '0;
            snap_valid <= 1'b0;
        end else if (capture) begin
            snap_cyc   <= cyc;
            snap_stl   <= stl;
            snap_fls   <= fls;
            snap_ret   <= ret;
            snap_valid <= 1'b1;
        end else if (snap_ack_i) begin
            snap_valid <= 1'b0;
        end
    end

    assign cycle_cnt_o  = cyc;
    assign stall_cnt_o  = stl;
    assign flush_cnt_o  = fls;
    assign retire_cnt_o = ret;
    assign snap_cyc_o   = snap_cyc;
    assign snap_stl_o   = snap_stl;
    assign snap_fls_o   = snap_fls;
    assign snap_ret_o   = snap_ret;
    assign snap_valid_o = snap_valid;
    assign halt_o       = (state == HALT);
    assign state_o      = state;

endmodule
